// File: rtl/sc_regprbs_pkg.sv
// Shared constants for the seeded LFSR generator/checker pair.
// Holds the state encoding, default tap mask and lock/loss thresholds.
package sc_regprbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [7:0] REGPRBS_TAPS_DEF = 8'hB8;
  localparam int REGPRBS_LOCK_DEF = 4;
  localparam int REGPRBS_LOSS_DEF = 3;

endpackage

// File: rtl/sc_regprbs_step.sv
// Combinational LFSR next-word function.
// Shift left, feed back the parity of the tapped bits.
module sc_regprbs_step
  import sc_regprbs_pkg::*;
#(
  parameter int W = 8,
  parameter logic [W-1:0] TAPS = W'(REGPRBS_TAPS_DEF)
) (
  input  logic [W-1:0] word,
  output logic [W-1:0] next
);

  assign next = {word[W-2:0], ^(word & TAPS)};

endmodule

// File: rtl/sc_regprbs_checker.sv
// Receive-side PRBS checker: seeds from incoming words, locks after
// a run of correct predictions, then flags and counts mismatches.
module sc_regprbs_checker
  import sc_regprbs_pkg::*;
#(
  parameter int RegPRBS_DATAWIDTH = 8,
  parameter logic [RegPRBS_DATAWIDTH-1:0] RegPRBS_TAPS =
    RegPRBS_DATAWIDTH'(REGPRBS_TAPS_DEF),
  parameter int RegPRBS_LOCK_COUNT = REGPRBS_LOCK_DEF,
  parameter int RegPRBS_LOSS_COUNT = REGPRBS_LOSS_DEF,
  parameter int RegPRBS_ERRCOUNT_WIDTH = 8
) (
  input  logic SC_RegPRBS_CLOCK_50,
  input  logic SC_RegPRBS_RESET_InLow,
  input  logic [RegPRBS_DATAWIDTH-1:0] SC_RegPRBS_data_InBUS,
  input  logic SC_RegPRBS_valid_In,
  input  logic SC_RegPRBS_clear_In,
  output logic SC_RegPRBS_lock_Out,
  output logic SC_RegPRBS_error_Out,
  output logic [RegPRBS_ERRCOUNT_WIDTH-1:0] SC_RegPRBS_errcount_OutBUS,
  output logic [RegPRBS_DATAWIDTH-1:0] SC_RegPRBS_expected_OutBUS
);

  localparam int W   = RegPRBS_DATAWIDTH;
  localparam int MRW = $clog2(RegPRBS_LOCK_COUNT + 1);
  localparam int MSW = $clog2(RegPRBS_LOSS_COUNT + 1);
  localparam int CW  = RegPRBS_ERRCOUNT_WIDTH;

  logic clk;
  logic rst_n;
  logic [W-1:0] data;
  logic valid;

  assign clk   = SC_RegPRBS_CLOCK_50;
  assign rst_n = SC_RegPRBS_RESET_InLow;
  assign data  = SC_RegPRBS_data_InBUS;
  assign valid = SC_RegPRBS_valid_In;

  state_t state;
  logic [W-1:0] expected;
  logic [W-1:0] step_data;
  logic [W-1:0] step_exp;
  logic [MRW-1:0] match_run;
  logic [MSW-1:0] miss_run;
  logic [MRW-1:0] match_inc;
  logic [MSW-1:0] miss_inc;
  logic [CW-1:0] errcount;
  logic match;
  logic miss_locked;

  sc_regprbs_step #(.W(W), .TAPS(RegPRBS_TAPS)) u_step_data (
    .word (data),
    .next (step_data)
  );

  sc_regprbs_step #(.W(W), .TAPS(RegPRBS_TAPS)) u_step_exp (
    .word (expected),
    .next (step_exp)
  );

  assign match       = (data == expected);
  assign match_inc   = match_run + 1'b1;
  assign miss_inc    = miss_run + 1'b1;
  assign miss_locked = valid && (state == LOCKED) && !match;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      expected  <= '0;
      match_run <= '0;
      miss_run  <= '0;
      errcount  <= '0;
      SC_RegPRBS_lock_Out  <= 1'b0;
      SC_RegPRBS_error_Out <= 1'b0;
    end else begin
      SC_RegPRBS_error_Out <= miss_locked;
      // clear has priority over a same-edge mismatch
      if (SC_RegPRBS_clear_In)
        errcount <= '0;
      else if (miss_locked && errcount != '1)
        errcount <= errcount + 1'b1;
      if (valid) begin
        unique case (state)
          HUNT: begin
            if (data != '0) begin
              expected  <= step_data;
              match_run <= '0;
              state     <= VERIFY;
            end
          end
          VERIFY: begin
            if (match) begin
              expected  <= step_data;
              match_run <= match_inc;
              if (match_inc == MRW'(RegPRBS_LOCK_COUNT)) begin
                state    <= LOCKED;
                miss_run <= '0;
                SC_RegPRBS_lock_Out <= 1'b1;
              end
            end else if (data != '0) begin
              expected  <= step_data;
              match_run <= '0;
            end else begin
              state <= HUNT;
            end
          end
          LOCKED: begin
            // prediction free-runs; bad data never reseeds
            expected <= step_exp;
            if (match) begin
              miss_run <= '0;
            end else begin
              miss_run <= miss_inc;
              if (miss_inc == MSW'(RegPRBS_LOSS_COUNT)) begin
                state     <= HUNT;
                match_run <= '0;
                SC_RegPRBS_lock_Out <= 1'b0;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

  assign SC_RegPRBS_errcount_OutBUS = errcount;
  assign SC_RegPRBS_expected_OutBUS = expected;

endmodule

// File: tb/tb_sc_regprbs_checker.sv
// Bench for sc_regprbs_checker: directed scenarios plus random
// traffic checked every cycle against a behavioural model.
module tb_sc_regprbs_checker;

  localparam logic [7:0] TAPS = 8'hB8;
  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] data;
  logic valid;
  logic clear;
  logic lock;
  logic err;
  logic [7:0] cnt;
  logic [7:0] exp_bus;

  int checks = 0;
  int failures = 0;

  int m_state;
  logic [7:0] m_exp;
  int m_match;
  int m_miss;
  logic m_lock;
  logic m_err;
  int m_cnt;

  always #5 clk = ~clk;

  sc_regprbs_checker dut (
    .SC_RegPRBS_CLOCK_50        (clk),
    .SC_RegPRBS_RESET_InLow     (rst_n),
    .SC_RegPRBS_data_InBUS      (data),
    .SC_RegPRBS_valid_In        (valid),
    .SC_RegPRBS_clear_In        (clear),
    .SC_RegPRBS_lock_Out        (lock),
    .SC_RegPRBS_error_Out       (err),
    .SC_RegPRBS_errcount_OutBUS (cnt),
    .SC_RegPRBS_expected_OutBUS (exp_bus)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] nxt(input logic [7:0] w);
    int ones = 0;
    for (int i = 0; i < 8; i++)
      if (w[i] && TAPS[i]) ones++;
    return {w[6:0], (ones % 2) == 1};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_exp = 8'h00;
    m_match = 0;
    m_miss = 0;
    m_lock = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // 0 = hunting, 1 = verifying a seed, 2 = locked
  task automatic model_clk(input logic v, input logic [7:0] d,
                           input logic c);
    logic bad;
    m_err = 1'b0;
    if (v) begin
      if (m_state == 0) begin
        if (d != 0) begin
          m_exp = nxt(d);
          m_match = 0;
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (d == m_exp) begin
          m_exp = nxt(d);
          m_match++;
          if (m_match == LOCK) begin
            m_state = 2;
            m_lock = 1'b1;
            m_miss = 0;
          end
        end else if (d != 0) begin
          m_exp = nxt(d);
          m_match = 0;
        end else begin
          m_state = 0;
        end
      end else begin
        bad = (d != m_exp);
        m_exp = nxt(m_exp);
        if (!bad) begin
          m_miss = 0;
        end else begin
          m_err = 1'b1;
          m_miss++;
          if (m_cnt < 255) m_cnt++;
          if (m_miss == LOSS) begin
            m_state = 0;
            m_lock = 1'b0;
            m_match = 0;
          end
        end
      end
    end
    if (c) m_cnt = 0;
  endtask

  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic c);
    valid = v;
    data = d;
    clear = c;
    @(posedge clk);
    model_clk(v, d, c);
    #1;
    chk("lock", 32'(lock), 32'(m_lock));
    chk("error", 32'(err), 32'(m_err));
    chk("errcount", 32'(cnt), 32'(m_cnt));
    chk("expected", 32'(exp_bus), 32'(m_exp));
  endtask

  task automatic mid_reset();
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_lock", 32'(lock), 32'd0);
    chk("rst_error", 32'(err), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    chk("rst_exp", 32'(exp_bus), 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic seed_lock();
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h04, 0);
    cyc(1, 8'h08, 0);
    cyc(1, 8'h11, 0);
  endtask

  initial begin
    logic [7:0] d;
    logic v;
    logic c;
    int r;
    rst_n = 1'b0;
    valid = 1'b0;
    clear = 1'b0;
    data = 8'h00;
    model_reset();
    #12;
    chk("init_lock", 32'(lock), 32'd0);
    chk("init_cnt", 32'(cnt), 32'd0);
    chk("init_exp", 32'(exp_bus), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    seed_lock();
    chk("lock_after_seed", 32'(lock), 32'd1);
    chk("exp_after_seed", 32'(exp_bus), 32'h23);

    cyc(1, 8'h00, 0);
    chk("one_err_pulse", 32'(err), 32'd1);
    chk("one_err_cnt", 32'(cnt), 32'd1);
    cyc(1, 8'h47, 0);
    chk("freerun_lock", 32'(lock), 32'd1);
    chk("freerun_exp", 32'(exp_bus), 32'h8E);

    cyc(1, 8'hAA, 0);
    cyc(1, 8'hAA, 0);
    cyc(1, 8'hAA, 0);
    chk("loss_lock", 32'(lock), 32'd0);
    chk("loss_cnt", 32'(cnt), 32'd4);
    seed_lock();
    chk("relock", 32'(lock), 32'd1);

    cyc(1, 8'hAA, 0);
    cyc(1, 8'hAA, 0);
    cyc(1, 8'hAA, 0);
    cyc(1, 8'h00, 0);
    cyc(1, 8'h00, 0);
    cyc(0, 8'h55, 0);
    cyc(1, 8'h01, 0);
    chk("hunt_seed_exp", 32'(exp_bus), 32'h02);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h04, 0);
    cyc(1, 8'h08, 0);
    chk("no_early_lock", 32'(lock), 32'd0);
    cyc(1, 8'h11, 0);
    chk("hunt_relock", 32'(lock), 32'd1);

    cyc(1, 8'h99, 1);
    chk("clear_wins", 32'(cnt), 32'd0);
    chk("clear_err", 32'(err), 32'd1);

    cyc(1, m_exp, 0);
    for (int i = 0; i < 260; i++) begin
      cyc(1, m_exp ^ 8'h5A, 0);
      cyc(1, m_exp, 0);
    end
    cyc(1, m_exp ^ 8'h5A, 0);
    chk("saturate", 32'(cnt), 32'hFF);

    mid_reset();
    cyc(1, 8'h01, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h04, 0);
    cyc(1, 8'h08, 0);
    chk("post_rst_nolock", 32'(lock), 32'd0);
    cyc(1, 8'h11, 0);
    chk("post_rst_lock", 32'(lock), 32'd1);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        mid_reset();
      end else begin
        v = ($urandom_range(0, 7) != 0);
        c = ($urandom_range(0, 49) == 0);
        r = $urandom_range(0, 19);
        if (m_state != 0 && r < 16) d = m_exp;
        else if (r == 19) d = 8'h00;
        else d = 8'($urandom_range(1, 255));
        cyc(v, d, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
